scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clocks spent on each position; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin scanning.
REQ-005 SHALL have port stop  input  1  one-cycle request to end scanning.
REQ-006 SHALL have port hold  input  1  level; 1 freezes scan position and dwell count.
REQ-007 SHALL have port dir  input  1  scan direction; 0 = ascending, 1 = descending.
REQ-008 SHALL have port mask  input  8  bit k = 1 means position k takes part in the scan.
REQ-009 SHALL have port sel  output  3  current position; drives decoder in[2:0].
REQ-010 SHALL have port en  output  1  drives decoder en; 1 only while scanning or holding.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when the scan completes a frame.
REQ-012 SHALL have port busy  output  1  1 whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SCAN and HOLD, and SHALL register all outputs.
REQ-014 IDLE: sel=0, en=0, wrap=0, busy=0, dwell counter=0.
REQ-015 IDLE with start=1 and mask!=0: next cycle go to SCAN, en=1, dwell=0, and sel = first set mask bit.
- dir=0: search upward from 0.
- dir=1: search downward from 7.
REQ-016 IDLE with start=1 and mask=0: stay in IDLE; no output change.
REQ-017 SCAN: dwell counts 0..DIV-1; at DIV-1, sel advances to the next set mask bit in direction dir, modulo 8, and dwell returns to 0.
- Each position is therefore held for exactly DIV clocks.
- DIV=1 advances every clock.
REQ-018 Skipped positions (mask bit 0) SHALL never appear on sel while en=1.
REQ-019 wrap SHALL pulse 1 in the cycle sel is updated when the new index is at or below the old index (dir=0), or at or above it (dir=1).
- This includes a single-bit mask, where the new index equals the old one.
REQ-020 SCAN with hold=1: go to HOLD; sel and dwell frozen; en stays 1; wrap=0.
REQ-021 HOLD with hold=0: return to SCAN; dwell resumes from its frozen value.
REQ-022 stop=1 in any state SHALL force IDLE on the next edge and SHALL take priority over start, hold and advance.
REQ-023 mask becoming 0 while in SCAN or HOLD SHALL force IDLE on the next edge.
REQ-024 Clearing the mask bit of the current sel mid-dwell SHALL NOT cut the dwell short; the next advance skips that bit.
REQ-025 start while in SCAN or HOLD SHALL be ignored.
REQ-026 A dir change SHALL take effect at the next advance only.
REQ-027 mask and dir SHALL be sampled in the advance cycle itself; no internal copy is kept.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force IDLE with sel=0, en=0, wrap=0, busy=0 and dwell=0.
REQ-029 Reset asserted mid-scan SHALL abort the scan; after release, the block SHALL wait for a new start.
REQ-030 start is not honoured on any edge where rst=1.

Verification
REQ-031 DIV=4, mask=FF, dir=0, start pulse -> sel 0,1,...,7,0 at 4 clocks each, en=1, wrap=1 for one cycle at the 7->0 step.
REQ-032 mask=8'b1010_0100, dir=1, start -> sel 7,5,2,7; wrap pulses at the 2->7 step; sel never shows 6, 4, 3, 1 or 0.
REQ-033 hold=1 for 10 clocks at sel=3, dwell=2 -> sel stays 3 and en stays 1; after hold=0, 2 more clocks then sel=4.
REQ-034 start and stop in the same cycle from SCAN -> IDLE next cycle with en=0, sel=0, busy=0.
REQ-035 rst=1 between clock edges while sel=5 -> en=0, sel=0 with no clock edge; after release, start -> scan begins at the first set bit.
REQ-036 mask=8'b0001_0000, DIV=1 -> sel=4 constantly, en=1, wrap=1 every cycle; mask=0 -> IDLE next cycle.

Source files
------------

// File: rtl/scan_sequencer.sv
// Position scanner: steps a 3-bit decoder select through the enabled mask
// positions, dwelling DIV clocks on each, with hold, stop and frame-wrap pulse.
//
// state | meaning
// IDLE  | decoder off, sel parked at 0, waiting for start
// SCAN  | dwell counter running, sel advances at terminal count
// HOLD  | sel and dwell frozen, decoder still enabled
module scan_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       dir,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       en,
  output logic       wrap,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DIV - 1);

  state_t     state, state_nx;
  logic [7:0] dwell, dwell_nx;
  logic [2:0] sel_nx;
  logic [2:0] sel_adv;
  logic       en_nx, wrap_nx, busy_nx;

  function automatic logic [2:0] first_pos(input logic [7:0] m, input logic d);
    logic [2:0] p;
    logic [2:0] idx;
    logic       found;
    p     = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = d ? 3'(7 - i) : 3'(i);
      if (!found && m[idx]) begin
        p     = idx;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  // Steps 1..8 away from cur; step 8 lands back on cur for a single-bit mask.
  function automatic logic [2:0] next_pos(input logic [2:0] cur, input logic [7:0] m,
                                          input logic d);
    logic [2:0] p;
    logic [2:0] idx;
    logic       found;
    p     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = d ? (cur - 3'(i)) : (cur + 3'(i));
      if (!found && m[idx]) begin
        p     = idx;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  assign sel_adv = next_pos(sel, mask, dir);

  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    sel_nx   = sel;
    en_nx    = en;
    wrap_nx  = 1'b0;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        if (start && (mask != 8'd0)) begin
          state_nx = SCAN;
          sel_nx   = first_pos(mask, dir);
          dwell_nx = 8'd0;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      SCAN, HOLD: begin
        if (hold) begin
          state_nx = HOLD;
        end else begin
          // Releasing hold counts as a dwell clock, mirroring the hold entry cycle.
          state_nx = SCAN;
          if (dwell >= DWELL_LAST) begin
            sel_nx   = sel_adv;
            dwell_nx = 8'd0;
            wrap_nx  = dir ? (sel_adv >= sel) : (sel_adv <= sel);
          end else begin
            dwell_nx = dwell + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (stop || ((state != IDLE) && (mask == 8'd0))) begin
      state_nx = IDLE;
      sel_nx   = 3'd0;
      dwell_nx = 8'd0;
      en_nx    = 1'b0;
      wrap_nx  = 1'b0;
      busy_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dwell <= 8'd0;
      sel   <= 3'd0;
      en    <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      dwell <= dwell_nx;
      sel   <= sel_nx;
      en    <= en_nx;
      wrap  <= wrap_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a per-cycle vector table on a DIV=4
// instance plus hand-written hold, reset and DIV=1 sequences.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, hold, dir;
  logic [7:0] mask;
  logic [2:0] sel, sel1;
  logic       en, wrap, busy, en1, wrap1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       start, stop, hold, dir;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       en, wrap, busy;
  } vec_t;

  vec_t vq[$];

  scan_sequencer #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .mask(mask), .sel(sel), .en(en), .wrap(wrap), .busy(busy)
  );

  scan_sequencer #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .mask(mask), .sel(sel1), .en(en1), .wrap(wrap1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] s, input logic e,
                           input logic w, input logic b);
    check({tag, " sel"},  8'(sel),  8'(s));
    check({tag, " en"},   8'(en),   8'(e));
    check({tag, " wrap"}, 8'(wrap), 8'(w));
    check({tag, " busy"}, 8'(busy), 8'(b));
  endtask

  task automatic push(input int st, input int sp, input int h, input int d, input int m,
                      input int s, input int e, input int w, input int b);
    vq.push_back('{start: 1'(st), stop: 1'(sp), hold: 1'(h), dir: 1'(d), mask: 8'(m),
                   sel: 3'(s), en: 1'(e), wrap: 1'(w), busy: 1'(b)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic h, input logic d,
                       input logic [7:0] m);
    start = st; stop = sp; hold = h; dir = d; mask = m;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // start with empty mask is ignored
    push(1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    // full ascending frame, 4 clocks per position, wrap on 7->0
    push(1, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    for (int d = 1; d < 4; d++) push(0, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    for (int p = 1; p < 8; p++)
      for (int d = 0; d < 4; d++) push(0, 0, 0, 0, 8'hFF, p, 1, 0, 1);
    push(0, 0, 0, 0, 8'hFF, 0, 1, 1, 1);
    push(1, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    push(0, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    // start together with stop: stop wins
    push(1, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    // sparse descending mask 1010_0100
    push(1, 0, 0, 1, 8'hA4, 7, 1, 0, 1);
    for (int d = 1; d < 4; d++) push(0, 0, 0, 1, 8'hA4, 7, 1, 0, 1);
    for (int d = 0; d < 4; d++) push(0, 0, 0, 1, 8'hA4, 5, 1, 0, 1);
    for (int d = 0; d < 4; d++) push(0, 0, 0, 1, 8'hA4, 2, 1, 0, 1);
    push(0, 0, 0, 1, 8'hA4, 7, 1, 1, 1);
    push(0, 1, 0, 1, 8'hA4, 0, 0, 0, 0);
    // dir change mid-dwell only applies at the next advance
    push(1, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    for (int d = 1; d < 4; d++) push(0, 0, 0, 0, 8'hFF, 0, 1, 0, 1);
    push(0, 0, 0, 0, 8'hFF, 1, 1, 0, 1);
    for (int d = 1; d < 4; d++) push(0, 0, 0, 1, 8'hFF, 1, 1, 0, 1);
    push(0, 0, 0, 1, 8'hFF, 0, 1, 0, 1);
    for (int d = 1; d < 4; d++) push(0, 0, 0, 1, 8'hFF, 0, 1, 0, 1);
    push(0, 0, 0, 1, 8'hFF, 7, 1, 1, 1);
    // clearing the current bit keeps the dwell, next advance skips it
    for (int d = 1; d < 4; d++) push(0, 0, 0, 1, 8'h7F, 7, 1, 0, 1);
    push(0, 0, 0, 1, 8'h7F, 6, 1, 0, 1);
    // empty mask forces IDLE
    push(0, 0, 0, 1, 8'h00, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stop, vq[i].hold, vq[i].dir, vq[i].mask);
      step();
      check_out($sformatf("vec%0d", i), vq[i].sel, vq[i].en, vq[i].wrap, vq[i].busy);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // hold at sel=3, dwell=2 for 10 clocks
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    step();
    start = 1'b0;
    repeat (14) step();
    check_out("pre_hold", 3'd3, 1'b1, 1'b0, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 3'd3, 1'b1, 1'b0, 1'b1);
    end
    hold = 1'b0;
    step();
    check_out("release1", 3'd3, 1'b1, 1'b0, 1'b1);
    step();
    check_out("release2", 3'd4, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_out("hold_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-scan at sel=5
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check_out("pre_rst", 3'd5, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    check_out("start_in_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hA4);
    step();
    check_out("idle_after_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_out("restart", 3'd2, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // DIV=1 single-bit mask: wraps every clock on the same position
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    step();
    start = 1'b0;
    check("div1 first sel", 8'(sel1), 8'd4);
    check("div1 first wrap", 8'(wrap1), 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("div1 sel%0d", i), 8'(sel1), 8'd4);
      check($sformatf("div1 en%0d", i), 8'(en1), 8'd1);
      check($sformatf("div1 wrap%0d", i), 8'(wrap1), 8'd1);
    end
    mask = 8'h00;
    step();
    check("div1 idle en", 8'(en1), 8'd0);
    check("div1 idle busy", 8'(busy1), 8'd0);
    check("div1 idle sel", 8'(sel1), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
